// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {S_DWELL, S_SAMPLE, S_EVAL} state_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } result_t;
  localparam result_t RES_NONE = '0;
  // Number of active-low (pressed) row lines.
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows);
    count_low = '0;
    for (int i = 0; i < NUM_ROWS; i++) count_low = count_low + {2'b00, ~rows[i]};
  endfunction
  // Index of the lowest pressed row; only meaningful when some row is low.
  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
    first_low = !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the row lines, resets to idle (all ones)
// Ports: clk, reset_n (async, active-low), d (async rows in), q (synchronized rows)
module keypad_sync
  import keypad_pkg::*;
#(
  parameter int W = NUM_ROWS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-scanned, debounced 4x4 keypad decoder
// Ports: clk, reset_n (async, active-low), row_in (active-low rows),
//        col_out (active-low column drive), key_code (row*4+col, held after release),
//        key_valid (debounced key held), key_pressed (1-cycle new-key pulse)
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_pressed
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 2);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
  logic [NUM_ROWS-1:0] rows;
  state_t              state, state_next;
  logic [DW-1:0]       dwell_cnt;
  logic [1:0]          col;
  logic [4:0]          press_cnt;
  logic [3:0]          hit_code;
  result_t             cand, result;
  logic [SW-1:0]       stable_cnt, stable_next;
  logic                commit;
  keypad_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row_in),
    .q       (rows)
  );
  assign col_out = ~(4'b0001 << col);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_DWELL;
    else          state <= state_next;
  // Sampling in S_SAMPLE completes the SCAN_DIV-cycle dwell of each column.
  always_comb begin
    state_next  = state == S_DWELL  ? (dwell_cnt == DWELL_LAST ? S_SAMPLE : S_DWELL)
                : state == S_SAMPLE ? (col == 2'd3 ? S_EVAL : S_DWELL)
                : S_DWELL;
    result      = press_cnt == 5'd1 ? result_t'({1'b1, hit_code}) : RES_NONE;
    stable_next = result != cand ? SW'(1)
                : stable_cnt == STABLE_MAX ? stable_cnt : stable_cnt + 1'b1;
    // Fires only on the scan where the count first arrives at the threshold.
    commit      = state == S_EVAL && stable_next == STABLE_MAX
                  && (result != cand || stable_cnt != STABLE_MAX);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dwell_cnt   <= '0;
      col         <= '0;
      press_cnt   <= '0;
      hit_code    <= '0;
      cand        <= RES_NONE;
      stable_cnt  <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      if (state == S_DWELL) dwell_cnt <= dwell_cnt == DWELL_LAST ? '0 : dwell_cnt + 1'b1;
      if (state == S_SAMPLE) begin
        col       <= col + 2'd1;
        press_cnt <= press_cnt + {2'b00, count_low(rows)};
        if (rows != '1) hit_code <= {first_low(rows), col};
      end
      if (state == S_EVAL) begin
        press_cnt  <= '0;
        cand       <= result;
        stable_cnt <= stable_next;
      end
      if (commit) begin
        key_valid <= result.valid;
        if (result.valid && !(key_valid && key_code == result.code)) begin
          key_code    <= result.code;
          key_pressed <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed test of the keypad scanner against a keypad model
module tb_keypad_matrix_scanner;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys;
  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  logic [3:0]  walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );
  always #5 clk = ~clk;
  // Passive matrix: a held key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end
  always @(posedge clk) if (key_pressed === 1'b1) pulses++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0;
    keys    = '0;
    cycles(3);
    check("rst_col", col_out, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_pressed", key_pressed, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      check($sformatf("walk%0d", i), col_out, walk[i < 16 ? i / 4 : (i < 21 ? 0 : 1)]);
      @(negedge clk);
    end
    cycles(60);
    check("idle_valid", key_valid, 0);
    check("idle_pulses", pulses, 0);
    keys[9] = 1'b1;
    cycles(30);
    check("k9_early_valid", key_valid, 0);
    cycles(45);
    check("k9_valid", key_valid, 1);
    check("k9_code", key_code, 9);
    check("k9_pulses", pulses, 1);
    cycles(170);
    check("k9_hold_pulses", pulses, 1);
    check("k9_hold_valid", key_valid, 1);
    keys[9] = 1'b0;
    cycles(30);
    check("rel_early_valid", key_valid, 1);
    cycles(45);
    check("rel_valid", key_valid, 0);
    check("rel_code", key_code, 9);
    check("rel_pulses", pulses, 1);
    keys[9] = 1'b1;
    cycles(75);
    check("re_valid", key_valid, 1);
    check("re_pulses", pulses, 2);
    keys[9] = 1'b0;
    cycles(75);
    check("re_rel_valid", key_valid, 0);
    for (int i = 0; i < 10; i++) begin
      keys[9] = ~keys[9];
      cycles(17);
    end
    keys[9] = 1'b0;
    check("chat_valid", key_valid, 0);
    check("chat_pulses", pulses, 2);
    cycles(75);
    check("chat_after_valid", key_valid, 0);
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    cycles(75);
    check("multi_valid", key_valid, 0);
    check("multi_pulses", pulses, 2);
    keys[5] = 1'b0;
    cycles(75);
    check("k0_valid", key_valid, 1);
    check("k0_code", key_code, 0);
    check("k0_pulses", pulses, 3);
    keys[0] = 1'b0;
    keys[9] = 1'b1;
    cycles(75);
    check("k0k9_code", key_code, 9);
    check("k0k9_pulses", pulses, 4);
    for (int i = 0; i < 40 && col_out !== 4'b1101; i++) @(negedge clk);
    check("seek_col1", col_out, 4'b1101);
    #2 reset_n = 1'b0;
    #1;
    check("arst_col", col_out, 4'b1110);
    check("arst_code", key_code, 0);
    check("arst_valid", key_valid, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(30);
    check("post_rst_early", key_valid, 0);
    cycles(45);
    check("post_rst_valid", key_valid, 1);
    check("post_rst_code", key_code, 9);
    check("post_rst_pulses", pulses, 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
